// File: rtl/alu_rb_pkg.sv
// Shared sizes and payload types for the ALU result bank.
// Optional build macro: RB_OVERWRITE_PROTECT_EN (drop writes to unread entries).
package alu_rb_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic gt;
        logic st;
        logic eq;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        alu_flags_t          flags;
        logic [DATA_W-1:0]   data;
    } alu_rb_entry_t;

endpackage

// File: rtl/alu_rb_count.sv
// Occupancy counter driven by entry set/clear strobes; full/empty registered
// alongside count so all three always agree in the same cycle.
module alu_rb_count
    import alu_rb_pkg::*;
#(
    parameter int unsigned DEPTH = alu_rb_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count_d;

    // set and clr may both fire (different entries), netting zero change
    always_comb begin
        count_d = count + CNT_W'(set) - CNT_W'(clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/alu_result_bank.sv
// Small bank of ALU results with per-entry valid bits; reads consume entries.
// Build macro RB_OVERWRITE_PROTECT_EN: writes to unread entries are dropped.
module alu_result_bank
    import alu_rb_pkg::*;
#(
    parameter int unsigned DEPTH  = alu_rb_pkg::DEPTH,
    parameter int unsigned DATA_W = alu_rb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [FLAG_W-1:0] wr_flags,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_miss,
    output logic [DATA_W-1:0] rd_data,
    output logic [FLAG_W-1:0] rd_flags,
    output logic [DEPTH-1:0]  valid_mask,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overwrite_err
);

    logic [DATA_W-1:0] data_mem  [DEPTH];
    alu_flags_t        flags_mem [DEPTH];

    logic             wr_hit;
    logic             rd_hit;
    logic             same_addr;
    logic             overwrite;
    logic             store;
    logic             set_strb;
    logic             clr_strb;
    logic [DEPTH-1:0] valid_d;

    // Same-address read+write hands out the old entry and keeps the new one,
    // so it is neither an overwrite nor a change in occupancy.
    always_comb begin
        wr_hit    = valid_mask[wr_addr];
        rd_hit    = valid_mask[rd_addr];
        same_addr = (wr_addr == rd_addr);
        overwrite = wr_en & wr_hit & ~(rd_req & same_addr);
`ifdef RB_OVERWRITE_PROTECT_EN
        store     = wr_en & ~overwrite;
`else
        store     = wr_en;
`endif
        set_strb  = wr_en & ~wr_hit;
        clr_strb  = rd_req & rd_hit & ~(wr_en & same_addr);
    end

    always_comb begin
        valid_d = valid_mask;
        if (clr_strb) begin
            valid_d[rd_addr] = 1'b0;
        end
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
        end
    end

    // Storage is never reset; valid bits alone decide visibility
    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[wr_addr]  <= wr_data;
            flags_mem[wr_addr] <= alu_flags_t'(wr_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_mask    <= '0;
            rd_valid      <= 1'b0;
            rd_miss       <= 1'b0;
            rd_data       <= '0;
            rd_flags      <= '0;
            overwrite_err <= 1'b0;
        end else begin
            valid_mask    <= valid_d;
            rd_valid      <= rd_req & rd_hit;
            rd_miss       <= rd_req & ~rd_hit;
            overwrite_err <= overwrite;
            if (rd_req && rd_hit) begin
                rd_data  <= data_mem[rd_addr];
                rd_flags <= FLAG_W'(flags_mem[rd_addr]);
            end
        end
    end

    alu_rb_count #(
        .DEPTH (DEPTH)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .set   (set_strb),
        .clr   (clr_strb),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_alu_result_bank.sv
// Directed self-checking bench for alu_result_bank; expectations honour
// RB_OVERWRITE_PROTECT_EN when the bench is built with it.
module tb_alu_result_bank;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] wr_flags;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_valid;
    logic       rd_miss;
    logic [7:0] rd_data;
    logic [3:0] rd_flags;
    logic [7:0] valid_mask;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overwrite_err;

    int checks;
    int failures;

    alu_result_bank dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_flags      (wr_flags),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_miss       (rd_miss),
        .rd_data       (rd_data),
        .rd_flags      (rd_flags),
        .valid_mask    (valid_mask),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overwrite_err (overwrite_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rd_req = 1'b0;
    endtask

    logic [7:0] exp_ow_data;
    logic [3:0] exp_ow_flags;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef RB_OVERWRITE_PROTECT_EN
        exp_ow_data  = 8'h02;
        exp_ow_flags = 4'h2;
`else
        exp_ow_data  = 8'hFF;
        exp_ow_flags = 4'b0101;
`endif
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_flags = '0;
        rd_req = 1'b0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_mask", 32'(valid_mask), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_miss", 32'(rd_miss), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_rd_flags", 32'(rd_flags), 32'h0);
        chk("rst_ovr", 32'(overwrite_err), 32'd0);

        // single write then consuming read
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; wr_flags = 4'b1000;
        tick(); idle();
        chk("w3_mask", 32'(valid_mask), 32'h08);
        chk("w3_count", 32'(count), 32'd1);
        chk("w3_empty", 32'(empty), 32'd0);
        chk("w3_rd_valid", 32'(rd_valid), 32'd0);

        rd_req = 1'b1; rd_addr = 3'd3;
        tick(); idle();
        chk("r3_valid", 32'(rd_valid), 32'd1);
        chk("r3_data", 32'(rd_data), 32'h5A);
        chk("r3_flags", 32'(rd_flags), 32'b1000);
        chk("r3_mask", 32'(valid_mask), 32'h00);
        chk("r3_empty", 32'(empty), 32'd1);
        chk("r3_count", 32'(count), 32'd0);
        tick();
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_hold", 32'(rd_data), 32'h5A);

        // read miss while empty
        rd_req = 1'b1; rd_addr = 3'd5;
        tick(); idle();
        chk("miss_miss", 32'(rd_miss), 32'd1);
        chk("miss_valid", 32'(rd_valid), 32'd0);
        chk("miss_count", 32'(count), 32'd0);
        chk("miss_hold", 32'(rd_data), 32'h5A);
        tick();
        chk("miss_clear", 32'(rd_miss), 32'd0);

        // fill every entry with data = address
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i); wr_flags = 4'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        idle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_mask", 32'(valid_mask), 32'hFF);
        chk("fill_ovr", 32'(overwrite_err), 32'd0);

        // overwrite while full
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF; wr_flags = 4'b0101;
        tick(); idle();
        chk("ow_pulse", 32'(overwrite_err), 32'd1);
        chk("ow_count", 32'(count), 32'd8);
        chk("ow_full", 32'(full), 32'd1);
        tick();
        chk("ow_pulse_end", 32'(overwrite_err), 32'd0);

        rd_req = 1'b1; rd_addr = 3'd2;
        tick(); idle();
        chk("ow_rd_data", 32'(rd_data), 32'(exp_ow_data));
        chk("ow_rd_flags", 32'(rd_flags), 32'(exp_ow_flags));
        chk("ow_rd_count", 32'(count), 32'd7);
        chk("ow_rd_full", 32'(full), 32'd0);

        // drain entry 4 and reload it with 8'h22
        rd_req = 1'b1; rd_addr = 3'd4;
        tick(); idle();
        chk("r4_data", 32'(rd_data), 32'h04);
        chk("r4_count", 32'(count), 32'd6);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h22; wr_flags = 4'b0010;
        tick(); idle();
        chk("w4_ovr", 32'(overwrite_err), 32'd0);
        chk("w4_count", 32'(count), 32'd7);

        // same-address write and read
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h11; wr_flags = 4'b0001;
        rd_req = 1'b1; rd_addr = 3'd4;
        tick(); idle();
        chk("same_valid", 32'(rd_valid), 32'd1);
        chk("same_data", 32'(rd_data), 32'h22);
        chk("same_flags", 32'(rd_flags), 32'b0010);
        chk("same_ovr", 32'(overwrite_err), 32'd0);
        chk("same_mask", 32'(valid_mask), 32'hFB);
        chk("same_count", 32'(count), 32'd7);
        rd_req = 1'b1; rd_addr = 3'd4;
        tick(); idle();
        chk("same_new_data", 32'(rd_data), 32'h11);
        chk("same_new_count", 32'(count), 32'd6);

        // write and read of different addresses in one edge
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h33; wr_flags = 4'b1111;
        rd_req = 1'b1; rd_addr = 3'd5;
        tick(); idle();
        chk("diff_data", 32'(rd_data), 32'h05);
        chk("diff_mask", 32'(valid_mask), 32'hCF);
        chk("diff_count", 32'(count), 32'd6);
        chk("diff_ovr", 32'(overwrite_err), 32'd0);

        // reset wins over a pending read of a valid entry
        rd_req = 1'b1; rd_addr = 3'd1; reset = 1'b1;
        tick(); idle();
        chk("rr_valid", 32'(rd_valid), 32'd0);
        chk("rr_miss", 32'(rd_miss), 32'd0);
        chk("rr_mask", 32'(valid_mask), 32'h00);
        chk("rr_count", 32'(count), 32'd0);
        chk("rr_empty", 32'(empty), 32'd1);
        chk("rr_data", 32'(rd_data), 32'h00);
        reset = 1'b0;
        tick();
        chk("rr_after_valid", 32'(rd_valid), 32'd0);
        chk("rr_after_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
